alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: the operand data width in bits.
REQ-002 The block SHALL have parameter NSRC, default 4: the number of selectable sources, minimum 2.
REQ-003 The block SHALL have parameter CONST_IDX, default 1: the source index that yields the constant instead of data_in.
REQ-004 The block SHALL have parameter CONST_VAL, default 4: the constant value (PC increment), WIDTH bits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port selector, input, SW bits (SW = clog2(NSRC), minimum 1): the source index.
REQ-008 The block SHALL have port mode, input, 2 bits: the extension mode applied after selection.
REQ-009 The block SHALL have port data_in, input, NSRC*WIDTH bits: flattened sources, with source k at bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_valid, input, 1 bit: the upstream operand is valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the stage can accept an operand.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the registered operand.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream consumer (the ALU) accepts.
REQ-015 The block SHALL have port sel_err, output, 1 bit: a sticky flag set when an operand is accepted with an out-of-range selector.

Function
REQ-016 The block SHALL select a source as follows: selector==CONST_IDX gives CONST_VAL; selector<NSRC gives source[selector]; selector>=NSRC gives 0.
REQ-017 The block SHALL apply mode to the selected value (low half = bits [WIDTH/2-1:0]):
- 00: pass-through.
- 01: sign-extend the low half.
- 10: sign-extend the low half, then shift left by 2 with the top bits discarded.
- 11: zero-extend the low half.
REQ-018 The block SHALL apply mode to the constant source as well.
REQ-019 The block SHALL accept an input when in_valid and in_ready are both high at a rising edge.
REQ-020 The block SHALL present an accepted operand on out_data with out_valid high on the cycle after acceptance (latency 1), provided the output register is empty or draining.
REQ-021 The block SHALL retire an output when out_valid and out_ready are both high at a rising edge.
REQ-022 The block SHALL sustain a throughput of one operand per cycle while out_ready stays high.
REQ-023 The block SHALL hold two storage entries: the output register and a skid register.
REQ-024 The block SHALL send an accepted operand to the skid register when the output register is full and out_ready is low.
REQ-025 The block SHALL drive in_ready = !skid_valid, registered, so that in_ready has no combinational path from out_ready.
REQ-026 When the skid register is full and out_ready is high, the block SHALL move the skid entry to the output register and raise in_ready the next cycle.
REQ-027 The block SHALL preserve operand order; it SHALL never drop or duplicate an operand.
REQ-028 While out_valid is high and out_ready is low, the block SHALL keep out_data stable.
REQ-029 On a simultaneous accept and retire with an empty skid register, the block SHALL load the new operand into the output register and keep out_valid high.
REQ-030 The block SHALL evaluate selector and mode only at acceptance; changes while in_valid is low SHALL have no effect.
REQ-031 The block SHALL set sel_err on the acceptance edge of an out-of-range selector, and the stored operand SHALL be 0 after mode.
REQ-032 Once set, sel_err SHALL stay high until reset.

Reset
REQ-033 While reset is high at a rising edge, the block SHALL clear out_valid, skid_valid and sel_err to 0.
REQ-034 While reset is high at a rising edge, the block SHALL clear out_data and the skid data to 0.
REQ-035 The block SHALL hold in_ready at 0 during reset and SHALL drive it to 1 on the first cycle after reset deasserts.
REQ-036 Assertion of reset mid-transfer SHALL discard both entries; no operand SHALL appear after reset.

Structure
REQ-037 The shared package cpu_pkg SHALL hold the mode encodings (MODE_PASS, MODE_SEXT, MODE_SEXT_SL2, MODE_ZEXT) and the default PC increment constant.
REQ-038 The selection and extension logic SHALL be combinational inside alu_operand_stage.
REQ-039 The two-entry buffering SHALL be one sub-module, operand_skid_buf, parametrised by WIDTH.

Verification
REQ-040 Bench scenario, pass-through: with out_ready=1, WIDTH=32, selector=0, mode=00, source0=0x12345678 and a single in_valid pulse, out_data SHALL be 0x12345678 with out_valid high exactly one cycle later.
REQ-041 Bench scenario, constant and extension modes:
- selector=1, mode=00 SHALL give 0x00000004.
- selector=2, source2=0x0000FFFC, mode=01 SHALL give 0xFFFFFFFC.
- the same input with mode=10 SHALL give 0xFFFFFFF0.
- the same input with mode=11 SHALL give 0x0000FFFC.
REQ-042 Bench scenario, backpressure: with out_ready=0, operands 0xA then 0xB accepted back to back SHALL drop in_ready after the second; raising out_ready SHALL then deliver 0xA and 0xB in order, each once.
REQ-043 Bench scenario, streaming: with out_ready=1 and in_valid=1 for 8 cycles (operands 1..8), the bench SHALL observe outputs 1..8 on 8 consecutive cycles with in_ready constantly 1.
REQ-044 Bench scenario, selector error: with NSRC=3 and selector=3 accepted, out_data SHALL be 0 and sel_err SHALL be 1 and stay 1 across later valid operands until reset.
REQ-045 Bench scenario, reset mid-transfer: asserting reset with both entries full SHALL give out_valid=0, in_ready=0 during reset, in_ready=1 on the next cycle, and no stale operand on the output.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ALU operand path.
//
// Contents:
//   mode_e        - extension modes applied to a selected operand
//   PC_INCREMENT  - default PC increment, used as the constant source
package cpu_pkg;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_SEXT     = 2'b01,
    MODE_SEXT_SL2 = 2'b10,
    MODE_ZEXT     = 2'b11
  } mode_e;

  localparam logic [31:0] PC_INCREMENT = 32'd4;

endpackage

// File: rtl/operand_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus a skid register.
// in_ready comes from the skid register state only, so it has no
// combinational path from out_ready.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_data, in_valid   - upstream operand and its valid
//   in_ready            - buffer can accept an operand this cycle
//   out_data, out_valid - registered operand presented downstream
//   out_ready           - downstream accepts out_data this cycle
module operand_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;

  // Reset gates in_ready so nothing is accepted while the stage is being
  // cleared; otherwise the stage is ready whenever the skid slot is free.
  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;

  // The skid slot only fills when the output register is full and stalled,
  // so a full skid implies a full output register. A full skid drains into
  // the output register as soon as out_ready is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects one of NSRC sources (or a constant), applies
// a sign/zero extension mode, and registers the result through a two-entry
// skid buffer.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   selector            - source index; CONST_IDX selects CONST_VAL
//   mode                - extension mode (cpu_pkg::mode_e)
//   data_in             - flattened sources, source k at [k*WIDTH +: WIDTH]
//   in_valid, in_ready  - upstream handshake
//   out_data, out_valid - registered operand to the ALU
//   out_ready           - ALU accepts out_data
//   sel_err             - sticky: an operand was accepted with a bad selector
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NSRC      = 4,
  parameter int               CONST_IDX = 1,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(PC_INCREMENT),
  localparam int              SW        = (NSRC > 2) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW-1:0]         selector,
  input  logic [1:0]            mode,
  input  logic [NSRC*WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] selected;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sext_low;
  logic [WIDTH-1:0] zext_low;
  logic             out_of_range;

  // The constant index takes priority over the data sources; any index
  // past the last source yields zero, so every mode then produces zero.
  always_comb begin
    selected     = '0;
    out_of_range = 1'b0;
    if (int'(selector) == CONST_IDX) begin
      selected = CONST_VAL;
    end else if (int'(selector) >= NSRC) begin
      out_of_range = 1'b1;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (int'(selector) == k) begin
          selected = data_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign sext_low = {{(WIDTH-HW){selected[HW-1]}}, selected[HW-1:0]};
  assign zext_low = {{(WIDTH-HW){1'b0}}, selected[HW-1:0]};

  // Extension is applied after selection, constant source included.
  always_comb begin
    operand = selected;
    case (mode_e'(mode))
      MODE_PASS:     operand = selected;
      MODE_SEXT:     operand = sext_low;
      MODE_SEXT_SL2: operand = sext_low << 2;
      MODE_ZEXT:     operand = zext_low;
      default:       operand = selected;
    endcase
  end

  operand_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .in_data  (operand),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Sticky error: only an accepted operand can set it, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (in_valid && in_ready && out_of_range) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (WIDTH=32, NSRC=3).
module tb_alu_operand_stage;

  localparam int WIDTH = 32;
  localparam int NSRC  = 3;

  logic              clk;
  logic              reset;
  logic [1:0]        selector;
  logic [1:0]        mode;
  logic [NSRC*WIDTH-1:0] data_in;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(
    .WIDTH(WIDTH),
    .NSRC (NSRC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .selector (selector),
    .mode     (mode),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    selector = 2'd0; mode = 2'd0; data_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready actual=%b expected=0", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data actual=%h expected=00000000", out_data); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_err actual=%b expected=0", sel_err); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready actual=%b expected=1", in_ready); end
  endtask

  task automatic test_pass_through;
    out_ready = 1'b1; selector = 2'd0; mode = 2'd0;
    data_in[0 +: 32] = 32'h12345678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pass_out_valid actual=%b expected=1", out_valid); end
    checks++; if (out_data !== 32'h12345678) begin errors++; $display("[TB] FAIL pass_out_data actual=%h expected=12345678", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pass_retired actual=%b expected=0", out_valid); end
  endtask

  task automatic test_const_ext;
    logic [1:0]  sel_tab  [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0]  mode_tab [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] exp_tab  [5] = '{32'h00000004, 32'hFFFFFFFC, 32'hFFFFFFF0,
                                  32'h0000FFFC, 32'h00000010};
    out_ready = 1'b1;
    data_in[32 +: 32] = 32'hDEADBEEF;
    data_in[64 +: 32] = 32'h0000FFFC;
    for (int i = 0; i < 5; i++) begin
      selector = sel_tab[i]; mode = mode_tab[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[i]) begin
        errors++;
        $display("[TB] FAIL const_ext_%0d actual=%h/%b expected=%h/1", i, out_data, out_valid, exp_tab[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; selector = 2'd0; mode = 2'd0;
    data_in[0 +: 32] = 32'h0000000A; in_valid = 1'b1;
    @(negedge clk);
    data_in[0 +: 32] = 32'h0000000B;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_first actual=%b expected=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_drop actual=%b expected=0", in_ready); end
    selector = 2'd2; mode = 2'b11;
    @(negedge clk);
    checks++; if (out_data !== 32'hA || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold actual=%h/%b expected=0000000a/1", out_data, out_valid); end
    selector = 2'd0; mode = 2'd0;
    out_ready = 1'b1;
    #1;
    checks++; if (out_data !== 32'hA) begin errors++; $display("[TB] FAIL bp_first_out actual=%h expected=0000000a", out_data); end
    @(negedge clk);
    checks++; if (out_data !== 32'hB || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_out actual=%h/%b expected=0000000b/1", out_data, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_restore actual=%b expected=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup actual=%b expected=0", out_valid); end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1; selector = 2'd0; mode = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      data_in[0 +: 32] = 32'(i); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready_%0d actual=%b expected=1", i, in_ready); end
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'(i - 1)) begin
          errors++;
          $display("[TB] FAIL stream_out_%0d actual=%h/%b expected=%h/1", i - 1, out_data, out_valid, 32'(i - 1));
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd8) begin errors++; $display("[TB] FAIL stream_out_8 actual=%h/%b expected=00000008/1", out_data, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain actual=%b expected=0", out_valid); end
  endtask

  task automatic test_sel_err;
    out_ready = 1'b1;
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL selerr_idle actual=%b expected=0", sel_err); end
    data_in = {NSRC{32'hFFFFFFFF}};
    selector = 2'd3; mode = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL selerr_data actual=%h/%b expected=00000000/1", out_data, out_valid); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("[TB] FAIL selerr_set actual=%b expected=1", sel_err); end
    selector = 2'd0; mode = 2'd0; data_in[0 +: 32] = 32'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h55) begin errors++; $display("[TB] FAIL selerr_next_data actual=%h expected=00000055", out_data); end
    @(negedge clk);
    checks++; if (sel_err !== 1'b1) begin errors++; $display("[TB] FAIL selerr_sticky actual=%b expected=1", sel_err); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; selector = 2'd0; mode = 2'd0;
    data_in[0 +: 32] = 32'h11; in_valid = 1'b1;
    @(negedge clk);
    data_in[0 +: 32] = 32'h22;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_data !== 32'h11) begin errors++; $display("[TB] FAIL mid_full actual=%b/%h expected=0/00000011", in_ready, out_data); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready_in_reset actual=%b expected=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_cleared actual=%h/%b expected=00000000/0", out_data, out_valid); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_sel_err actual=%b expected=0", sel_err); end
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready_after actual=%b expected=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_%0d actual=%b/%h expected=0", i, out_valid, out_data); end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_const_ext();
    test_backpressure();
    test_streaming();
    test_sel_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
